// File: rtl/thermistor_sampler.sv
// Thermistor ADC front end: 2-flop synchroniser, sample divider, 2^LOG2_AVG window averager,
// sticky valid/overrun handshake and hysteretic alarm. Define THERM_MINMAX_EN to build min/max tracking.
module thermistor_sampler #(
   parameter int DATA_W     = 8,
   parameter int LOG2_AVG   = 2,
   parameter int SAMPLE_DIV = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              enable,
   input  logic [DATA_W-1:0] adc_in,
   input  logic [DATA_W-1:0] thr_hi,
   input  logic [DATA_W-1:0] thr_lo,
   input  logic              rd_ack,
   output logic [DATA_W-1:0] avg_out,
   output logic              avg_valid,
   output logic              overrun,
   output logic              alarm,
   output logic [DATA_W-1:0] min_out,
   output logic [DATA_W-1:0] max_out
);

   localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
   localparam int ACC_W = DATA_W + LOG2_AVG;
   localparam int N_W   = LOG2_AVG + 1;
   localparam logic [N_W-1:0]   N_FULL   = N_W'(2 ** LOG2_AVG);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);

   typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

   state_t             state, state_next;
   logic [DATA_W-1:0]  sync1, sync2;
   logic [DIV_W-1:0]   div_cnt, div_cnt_next;
   logic [ACC_W-1:0]   acc, acc_next, acc_base;
   logic [N_W-1:0]     n, n_next, n_base;
   logic               tick;
   logic [DATA_W-1:0]  avg_new;

   assign tick    = enable && (div_cnt == DIV_LAST);
   assign avg_new = DATA_W'(acc >> LOG2_AVG);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync1   <= '0;
         sync2   <= '0;
         div_cnt <= '0;
         state   <= IDLE;
         acc     <= '0;
         n       <= '0;
      end else begin
         sync1   <= adc_in;
         sync2   <= sync1;
         div_cnt <= div_cnt_next;
         state   <= state_next;
         acc     <= acc_next;
         n       <= n_next;
      end
   end

   // A tick landing in IDLE or DONE starts a fresh window, so SAMPLE_DIV=1 loses no samples.
   always_comb begin
      div_cnt_next = '0;
      state_next   = IDLE;
      acc_next     = '0;
      n_next       = '0;
      acc_base     = (state == ACCUM) ? acc : '0;
      n_base       = (state == ACCUM) ? n : '0;
      if (enable) begin
         div_cnt_next = (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
         state_next   = ACCUM;
         acc_next     = acc_base;
         n_next       = n_base;
         if (tick) begin
            acc_next = acc_base + ACC_W'(sync2);
            n_next   = n_base + N_W'(1);
            if (n_base + N_W'(1) == N_FULL) begin
               state_next = DONE;
            end
         end
      end
   end

   // DONE takes precedence over a coincident acknowledge.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         avg_out   <= '0;
         avg_valid <= 1'b0;
         overrun   <= 1'b0;
         alarm     <= 1'b0;
      end else if (state == DONE) begin
         avg_out   <= avg_new;
         avg_valid <= 1'b1;
         if (avg_valid && !rd_ack) begin
            overrun <= 1'b1;
         end
         if (avg_new >= thr_hi) begin
            alarm <= 1'b1;
         end else if (avg_new <= thr_lo) begin
            alarm <= 1'b0;
         end
      end else if (rd_ack && avg_valid) begin
         avg_valid <= 1'b0;
         overrun   <= 1'b0;
      end
   end

`ifdef THERM_MINMAX_EN
   logic mm_seen;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         min_out <= '0;
         max_out <= '0;
         mm_seen <= 1'b0;
      end else if (state == DONE) begin
         if (!mm_seen || avg_new < min_out) begin
            min_out <= avg_new;
         end
         if (!mm_seen || avg_new > max_out) begin
            max_out <= avg_new;
         end
         mm_seen <= 1'b1;
      end
   end
`else
   assign min_out = '0;
   assign max_out = '0;
`endif

endmodule

// File: doc/thermistor_sampler.md
Name: thermistor_sampler

Overview:
Parametrised sampling front end for the parallel thermistor ADC bus that currently enters the processor as eight discrete pins. It synchronises a DATA_W-bit ADC word and samples it at a programmable rate. It averages 2^LOG2_AVG samples per window and presents the result to the processor through a sticky valid/acknowledge handshake. It also drives a hysteretic over-temperature alarm output.

Parameters:
- DATA_W, 8: ADC word width in bits.
- LOG2_AVG, 2: log2 of the number of samples averaged per window (0 means no averaging).
- SAMPLE_DIV, 4: number of clock cycles between sample ticks, must be at least 1.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  runs the sampler; when low, the block holds in IDLE.
- adc_in  in  DATA_W  raw ADC bus from the pins, asynchronous to clock.
- thr_hi  in  DATA_W  alarm set threshold.
- thr_lo  in  DATA_W  alarm clear threshold.
- rd_ack  in  1  processor acknowledge; clears avg_valid.
- avg_out  out  DATA_W  most recent window average.
- avg_valid  out  1  sticky flag: an unread average is available.
- overrun  out  1  sticky flag: an average was overwritten before it was acknowledged.
- alarm  out  1  over-temperature indication.
- min_out  out  DATA_W  minimum average seen (optional feature).
- max_out  out  DATA_W  maximum average seen (optional feature).

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs return to 0.
  - Synchroniser, divider, sample count and accumulator clear to 0.
  - FSM goes to IDLE.
  - Takes effect mid-window; the partial sum is discarded.
- Synchroniser: two flops on adc_in. A sample therefore reflects the pins as they were 2 edges earlier.
- Divider:
  - Counts 0 to SAMPLE_DIV-1 while enable=1 and wraps.
  - tick is asserted when the count equals SAMPLE_DIV-1.
  - The count is held at 0 while enable=0.
- FSM states:
  - IDLE: when enable=1, go to ACCUM; acc=0, n=0.
  - ACCUM: on each tick, acc += sync sample and n += 1. When the tick takes n to 2^LOG2_AVG, go to DONE.
  - DONE (one cycle):
    - avg_out = acc >> LOG2_AVG (truncating).
    - Update alarm and avg_valid.
    - Clear acc and n.
    - Return to ACCUM if enable=1, otherwise to IDLE.
  - If enable falls in ACCUM, go to IDLE and discard the partial window. avg_out, avg_valid and alarm keep their values.
- Accumulator width is DATA_W+LOG2_AVG, so it never overflows.
- Latency: with enable rising before edge 0, ticks occur at edges SAMPLE_DIV-1, 2*SAMPLE_DIV-1, and so on. The DONE update is visible after edge 2^LOG2_AVG*SAMPLE_DIV.
- Handshake:
  - avg_valid sets in DONE and clears on an rd_ack edge.
  - If DONE and rd_ack occur in the same cycle, DONE wins: avg_valid stays 1 and overrun is not set.
  - If DONE occurs while avg_valid=1 and rd_ack=0, overrun is set. Overrun clears only with rd_ack, and only in a cycle without DONE.
  - rd_ack while avg_valid=0 has no effect.
- Alarm, evaluated only in DONE, using the new average:
  - avg >= thr_hi sets alarm to 1.
  - Otherwise, avg <= thr_lo clears alarm to 0.
  - Otherwise, alarm holds its value.
  - If thr_lo >= thr_hi, set takes priority.
- SAMPLE_DIV=1: a tick occurs every enabled cycle. LOG2_AVG=0: avg_out is the single sample.

Optional Feature:
- Macro: THERM_MINMAX_EN.
- Defined: min_out and max_out track the extreme averages seen since reset, updated in DONE.
  - The first DONE after reset loads both with the average.
  - After that, min_out takes the new average when it is lower and max_out when it is higher.
- Not defined: no min/max registers are built; min_out and max_out are tied to 0.

Test Plan:
All cases use the defaults (DATA_W=8, LOG2_AVG=2, SAMPLE_DIV=4).
1. adc_in held at 8'h99 (pins 1,0,0,1,1,0,0,1), enable=1 -> after edge 16, avg_out=153, avg_valid=1, overrun=0, alarm=0 (with thr_hi=200, thr_lo=100).
2. Samples 10, 11, 12, 13 across a window -> avg_out=11 (sum 46, truncated >>2). A second window of 255s -> avg_out=255; the accumulator does not overflow.
3. No rd_ack across two windows -> overrun=1 at edge 32. rd_ack on edge 33 -> avg_valid=0 and overrun=0. rd_ack pulsed in the same cycle as DONE -> avg_valid stays 1.
4. Hysteresis with thr_hi=200, thr_lo=100: averages 210, 150, 90, 150 -> alarm 1, 1, 0, 0.
5. enable dropped after 2 ticks, then re-raised -> the first result needs 4 fresh ticks and avg_valid stays 0 in between. reset pulsed low mid-window -> all outputs 0 immediately, without waiting for a clock edge.
6. THERM_MINMAX_EN defined, averages 50, 20, 90 -> min_out=20, max_out=90. Macro undefined -> both read 0.
